nbc_serial_mac: RTL and testbench

- Downstream consumer of the non-zero bit compaction stage. Takes one compacted operand-pair vector, in which non-zero pairs are packed into the low lanes and zero pairs fill the upper lanes.
- Multiply-accumulates the pairs serially, one lane per clock, and stops early at the first zero lane.
- Returns an unsigned dot-product result and a count of consumed pairs over a valid/ready handshake to the accumulation datapath.

---
 rtl/nbc_serial_mac_pkg.sv | 30 +++
 rtl/nbc_lane_mul.sv | 12 +
 rtl/nbc_serial_mac.sv | 111 +++++++++++
 tb/tb_nbc_serial_mac.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/nbc_serial_mac_pkg.sv
// Shared definitions for the non-zero bit compaction datapath: state encoding,
// a constant clog2 and the lane-slice helper used by the compaction stages.
package nbc_serial_mac_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int VEC_MAX  = 256;
  localparam int LANE_MAX = 32;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

  // Lane i of a packed vector, lane 0 in the low bits; result is zero-extended.
  function automatic logic [LANE_MAX-1:0] lane_slice(input logic [VEC_MAX-1:0] vec,
                                                     input int lane,
                                                     input int width);
    logic [VEC_MAX-1:0] shifted;
    logic [LANE_MAX-1:0] mask;
    shifted = vec >> (lane * width);
    mask = (LANE_MAX'(1) << width) - LANE_MAX'(1);
    return LANE_MAX'(shifted) & mask;
  endfunction

endpackage

// File: rtl/nbc_lane_mul.sv
// Combinational unsigned lane multiplier for the serial MAC.
module nbc_lane_mul #(
  parameter int OP_WIDTH = 4
) (
  input  logic [OP_WIDTH-1:0]   a,
  input  logic [OP_WIDTH-1:0]   b,
  output logic [2*OP_WIDTH-1:0] prod
);

  assign prod = (2*OP_WIDTH)'(a) * (2*OP_WIDTH)'(b);

endmodule

// File: rtl/nbc_serial_mac.sv
// Serial multiply-accumulate over one compacted operand-pair vector, one lane
// per clock, stopping at the first zero lane.
//
// state | meaning
// IDLE  | waiting for a vector, in_ready=1
// RUN   | examining lane idx, accumulating non-zero pairs
// DONE  | result presented, waiting for out_ready
module nbc_serial_mac
  import nbc_serial_mac_pkg::*;
#(
  parameter int OP_WIDTH  = 4,
  parameter int N_INPUT   = 4,
  parameter int ACC_WIDTH = 2*OP_WIDTH + clog2(N_INPUT),
  parameter int CNT_WIDTH = clog2(N_INPUT+1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_INPUT*OP_WIDTH-1:0]   op_a,
  input  logic [N_INPUT*OP_WIDTH-1:0]   op_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_WIDTH-1:0]          out_acc,
  output logic [CNT_WIDTH-1:0]          out_count
);

  localparam int IDX_WIDTH = (N_INPUT > 1) ? clog2(N_INPUT) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_INPUT-1);

  logic [1:0]                  state, state_nxt;
  logic [N_INPUT*OP_WIDTH-1:0] a_reg, b_reg;
  logic [IDX_WIDTH-1:0]        idx;
  logic [ACC_WIDTH-1:0]        acc, acc_nxt;
  logic [CNT_WIDTH-1:0]        count, count_nxt;
  logic [OP_WIDTH-1:0]         a_lane, b_lane;
  logic [2*OP_WIDTH-1:0]       prod;
  logic                        lane_nz;
  logic                        run_last;

  assign a_lane = OP_WIDTH'(lane_slice(VEC_MAX'(a_reg), int'(idx), OP_WIDTH));
  assign b_lane = OP_WIDTH'(lane_slice(VEC_MAX'(b_reg), int'(idx), OP_WIDTH));

  nbc_lane_mul #(.OP_WIDTH(OP_WIDTH)) u_lane_mul (
    .a    (a_lane),
    .b    (b_lane),
    .prod (prod)
  );

  // A single zero operand makes the whole pair a terminating zero lane.
  assign lane_nz   = (a_lane != '0) && (b_lane != '0);
  assign run_last  = !lane_nz || (idx == LAST_IDX);
  assign acc_nxt   = lane_nz ? acc + ACC_WIDTH'(prod) : acc;
  assign count_nxt = lane_nz ? count + CNT_WIDTH'(1) : count;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (run_last)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      idx       <= '0;
      acc       <= '0;
      count     <= '0;
      out_acc   <= '0;
      out_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= op_a;
            b_reg <= op_b;
            idx   <= '0;
            acc   <= '0;
            count <= '0;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          count <= count_nxt;
          if (run_last) begin
            out_acc   <= acc_nxt;
            out_count <= count_nxt;
          end else begin
            idx <= idx + IDX_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nbc_serial_mac.sv
// Self-checking bench for nbc_serial_mac against a lane-by-lane dot-product model.
module tb_nbc_serial_mac;

  localparam int OPW  = 4;
  localparam int N    = 4;
  localparam int ACCW = 10;
  localparam int CNTW = 3;
  localparam int VW   = N*OPW;

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [VW-1:0]   op_a, op_b;
  logic            out_valid;
  logic            out_ready;
  logic [ACCW-1:0] out_acc;
  logic [CNTW-1:0] out_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  nbc_serial_mac dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count)
  );

  // Dot product over leading non-zero pairs; runs = cycles spent examining lanes.
  function automatic void model(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                output int acc, output int cnt, output int runs);
    int ai, bi;
    acc = 0; cnt = 0; runs = 0;
    for (int i = 0; i < N; i++) begin
      ai = int'(a[OPW*i +: OPW]);
      bi = int'(b[OPW*i +: OPW]);
      runs++;
      if (ai == 0 || bi == 0) break;
      acc += ai * bi;
      cnt++;
    end
  endfunction

  function automatic logic [VW-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {OPW'(l3), OPW'(l2), OPW'(l1), OPW'(l0)};
  endfunction

  task automatic run_vector(input string name, input logic [VW-1:0] a, input logic [VW-1:0] b,
                            input bit early_ready, input int hold, input bit scramble);
    int exp_acc, exp_cnt, exp_runs, runs, waits;
    bit ready_bad, stable_bad;
    logic [ACCW-1:0] acc_seen;
    logic [CNTW-1:0] cnt_seen;
    model(a, b, exp_acc, exp_cnt, exp_runs);
    waits = 0;
    while (!in_ready && waits < 20) begin
      @(negedge clock);
      waits++;
    end
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL %s in_ready_wait: in_ready=%b, required 1", name, in_ready);
    else n_pass++;
    in_valid = 1'b1; op_a = a; op_b = b;
    out_ready = early_ready;
    @(negedge clock);
    in_valid = 1'b0;
    runs = 0; ready_bad = 1'b0;
    while (out_valid !== 1'b1 && runs < 20) begin
      if (in_ready !== 1'b0) ready_bad = 1'b1;
      if (scramble) begin op_a = VW'($urandom); op_b = VW'($urandom); end
      runs++;
      @(negedge clock);
    end
    n_checks++;
    if (runs !== exp_runs || ready_bad)
      $display("FAIL %s run_cycles: got %0d (ready_bad=%0b), required %0d", name, runs, ready_bad, exp_runs);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b1 || out_acc !== ACCW'(exp_acc) || out_count !== CNTW'(exp_cnt))
      $display("FAIL %s result: valid=%b acc=%0d cnt=%0d, required valid=1 acc=%0d cnt=%0d",
               name, out_valid, out_acc, out_count, exp_acc, exp_cnt);
    else n_pass++;
    if (!early_ready) begin
      acc_seen = out_acc; cnt_seen = out_count; stable_bad = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_acc !== ACCW'(exp_acc) || out_count !== CNTW'(exp_cnt))
          stable_bad = 1'b1;
      end
      if (hold > 0) begin
        n_checks++;
        if (stable_bad)
          $display("FAIL %s backpressure: valid=%b ready=%b acc=%0d cnt=%0d, required 1/0/%0d/%0d",
                   name, out_valid, in_ready, out_acc, out_count, exp_acc, exp_cnt);
        else n_pass++;
      end
      out_ready = 1'b1;
    end
    @(negedge clock);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== ACCW'(exp_acc) || out_count !== CNTW'(exp_cnt))
      $display("FAIL %s release: valid=%b ready=%b acc=%0d cnt=%0d, required 0/1/%0d/%0d",
               name, out_valid, in_ready, out_acc, out_count, exp_acc, exp_cnt);
    else n_pass++;
  endtask

  task automatic check_idle(input string name);
    n_checks++;
    if (out_valid !== 1'b0 || out_acc !== '0 || out_count !== '0 || in_ready !== 1'b1)
      $display("FAIL %s: valid=%b acc=%0d cnt=%0d ready=%b, required 0/0/0/1",
               name, out_valid, out_acc, out_count, in_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    bit saw_valid;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_idle("reset_idle");
    // Produce a non-zero held result, then abort a vector mid-RUN.
    run_vector("pre_reset", pack4(3, 3, 3, 0), pack4(5, 5, 5, 0), 1'b1, 0, 1'b0);
    in_valid = 1'b1; op_a = pack4(9, 9, 9, 9); op_b = pack4(9, 9, 9, 9);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_idle("reset_mid_run");
    saw_valid = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (out_valid !== 1'b0) saw_valid = 1'b1;
    end
    n_checks++;
    if (saw_valid) $display("FAIL reset_no_output: out_valid seen after abort, required none");
    else n_pass++;
    // Abort while a result is held in DONE.
    in_valid = 1'b1; op_a = pack4(2, 2, 0, 0); op_b = pack4(3, 3, 0, 0);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_idle("reset_mid_done");
  endtask

  task automatic test_directed();
    run_vector("two_lanes",  pack4(1, 2, 0, 0),     pack4(3, 4, 0, 0),     1'b1, 0, 1'b0);
    run_vector("all_full",   pack4(15, 15, 15, 15), pack4(15, 15, 15, 15), 1'b1, 0, 1'b0);
    run_vector("all_zero",   pack4(0, 0, 0, 0),     pack4(0, 0, 0, 0),     1'b1, 0, 1'b0);
    run_vector("malformed",  pack4(0, 5, 0, 0),     pack4(0, 5, 0, 0),     1'b1, 0, 1'b0);
    run_vector("one_zero_op", pack4(4, 6, 7, 0),    pack4(2, 0, 3, 0),     1'b1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_vector("bp_hold", pack4(3, 4, 5, 0), pack4(6, 7, 8, 0), 1'b0, 5, 1'b0);
    run_vector("bp_next", pack4(2, 0, 0, 0), pack4(7, 0, 0, 0), 1'b0, 0, 1'b0);
  endtask

  task automatic test_scramble();
    run_vector("scramble_full", pack4(11, 3, 9, 14), pack4(2, 13, 6, 1), 1'b0, 2, 1'b1);
    run_vector("scramble_part", pack4(7, 8, 0, 4),   pack4(9, 10, 0, 4), 1'b1, 0, 1'b1);
  endtask

  task automatic test_random();
    logic [VW-1:0] a, b;
    int k;
    for (int t = 0; t < 24; t++) begin
      k = $urandom_range(0, N);
      a = '0; b = '0;
      for (int i = 0; i < N; i++) begin
        if (i < k) begin
          a[OPW*i +: OPW] = OPW'($urandom_range(1, 15));
          b[OPW*i +: OPW] = OPW'($urandom_range(1, 15));
        end else if (i == k && $urandom_range(0, 1) == 1) begin
          a[OPW*i +: OPW] = OPW'($urandom_range(1, 15));
        end else if (i > k && $urandom_range(0, 3) == 0) begin
          a[OPW*i +: OPW] = OPW'($urandom_range(1, 15));
          b[OPW*i +: OPW] = OPW'($urandom_range(1, 15));
        end
      end
      run_vector($sformatf("rand%0d", t), a, b, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
    @(negedge clock);
    test_reset();
    test_directed();
    test_backpressure();
    test_scramble();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
